// File: rtl/ortho_map_pkg.sv
// ortho_map_pkg
//   Shared definitions for the orthogonal-basis symbol mapper:
//   - width derivation helpers (symbol / word / index widths)
//   - state encoding of the output stage (EMPTY, SEND)
//   - binary-to-Gray conversion of a single dimension level
package ortho_map_pkg;

    // Output stage state: EMPTY holds nothing, SEND presents a symbol on x.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;

    function automatic int sym_width(input int num_dims, input int dim_width);
        return num_dims * dim_width;
    endfunction

    function automatic int word_width(input int syms_per_word, input int num_dims,
                                      input int dim_width);
        return syms_per_word * num_dims * dim_width;
    endfunction

    // A one-symbol word still needs a 1-bit index so the counter is never zero-width.
    function automatic int idx_width(input int syms_per_word);
        return (syms_per_word > 1) ? $clog2(syms_per_word) : 1;
    endfunction

    // Callers truncate the result to DIM_WIDTH; the zero-extended upper bits
    // shift in zeros, so the low DIM_WIDTH bits are the DIM_WIDTH-bit Gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/dim_gray_map.sv
// dim_gray_map
//   Combinational per-dimension level mapper. Each DIM_WIDTH-bit level of the
//   symbol is independently passed through or converted to Gray code; there is
//   no carry between dimensions.
//   Ports:
//     sym_in   in  SYM_WIDTH  raw symbol, dimension d at [d*DIM_WIDTH +: DIM_WIDTH]
//     gray_en  in  1          1 = Gray-map every level, 0 = pass through
//     sym_out  out SYM_WIDTH  mapped symbol, same layout as sym_in
module dim_gray_map
    import ortho_map_pkg::*;
#(
    parameter  int NUM_DIMS  = 3,
    parameter  int DIM_WIDTH = 2,
    localparam int SYM_WIDTH = NUM_DIMS * DIM_WIDTH
) (
    input  logic [SYM_WIDTH-1:0] sym_in,
    input  logic                 gray_en,
    output logic [SYM_WIDTH-1:0] sym_out
);

    for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
        logic [DIM_WIDTH-1:0] level;

        assign level = sym_in[d*DIM_WIDTH +: DIM_WIDTH];
        assign sym_out[d*DIM_WIDTH +: DIM_WIDTH] =
            gray_en ? DIM_WIDTH'(bin2gray(32'(level))) : level;
    end

endmodule

// File: rtl/ortho_symbol_mapper.sv
// ortho_symbol_mapper
//   Accepts wide data words over valid/ready and serialises each into
//   SYMS_PER_WORD symbols, one per symbol handshake, symbol 0 first. Each
//   symbol carries NUM_DIMS levels, optionally Gray-mapped per word.
//   Ports:
//     clk, rst   sole clock (rising edge) and asynchronous active-high reset
//     in_data    WORD_WIDTH data word, symbol s at [s*SYM_WIDTH +: SYM_WIDTH]
//     in_valid   in_data valid
//     in_ready   word can be accepted this cycle (combinational from out_ready)
//     gray_en    Gray-map the word being accepted
//     x          current symbol (registered)
//     out_valid  x valid (registered)
//     out_ready  downstream consumes x this cycle
//     out_last   x is the final symbol of its word (registered)
module ortho_symbol_mapper
    import ortho_map_pkg::*;
#(
    parameter  int NUM_DIMS      = 3,
    parameter  int DIM_WIDTH     = 2,
    parameter  int SYMS_PER_WORD = 4,
    localparam int SYM_WIDTH     = sym_width(NUM_DIMS, DIM_WIDTH),
    localparam int WORD_WIDTH    = word_width(SYMS_PER_WORD, NUM_DIMS, DIM_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  gray_en,
    output logic [SYM_WIDTH-1:0]  x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int               IDX_W    = idx_width(SYMS_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_WORD - 1);

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic                  gray_q,  gray_d;
    logic [SYM_WIDTH-1:0]  x_q,     x_d;
    logic                  last_q,  last_d;

    logic                  accept;
    logic                  sym_hs;
    logic [SYM_WIDTH-1:0]  map_in;
    logic                  map_gray;
    logic [SYM_WIDTH-1:0]  map_out;

    assign out_valid = (state_q == ST_SEND);
    assign out_last  = last_q;
    assign x         = x_q;

    // A new word fits when nothing is held, or the held symbol is the last
    // one and leaves this cycle: this is what makes back-to-back words gapless.
    assign in_ready = !out_valid || (out_ready && last_q);
    assign accept   = in_valid && in_ready;
    assign sym_hs   = out_valid && out_ready;

    // One mapper serves both paths: an accept maps symbol 0 of the incoming
    // word with the incoming gray_en; an advance maps the next stored symbol
    // with the gray setting latched for the current word.
    assign map_in   = accept ? in_data[SYM_WIDTH-1:0] : shift_q[SYM_WIDTH-1:0];
    assign map_gray = accept ? gray_en : gray_q;

    dim_gray_map #(
        .NUM_DIMS  (NUM_DIMS),
        .DIM_WIDTH (DIM_WIDTH)
    ) u_map (
        .sym_in  (map_in),
        .gray_en (map_gray),
        .sym_out (map_out)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        gray_d  = gray_q;
        x_d     = x_q;
        last_d  = last_q;

        if (accept) begin
            // Accept has priority: it only coincides with a handshake on the
            // last symbol, whose word is finished anyway.
            state_d = ST_SEND;
            idx_d   = '0;
            shift_d = in_data >> SYM_WIDTH;
            gray_d  = gray_en;
            x_d     = map_out;
            last_d  = (LAST_IDX == '0);
        end else if (sym_hs) begin
            if (last_q) begin
                state_d = ST_EMPTY;
                idx_d   = '0;
                last_d  = 1'b0;
            end else begin
                idx_d   = idx_q + 1'b1;
                x_d     = map_out;
                shift_d = shift_q >> SYM_WIDTH;
                last_d  = ((idx_q + 1'b1) == LAST_IDX);
            end
        end
    end

    // NOTE: the shift register is reset along with the control state so a
    // reset mid-word leaves no stored symbols behind to leak out later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            shift_q <= '0;
            gray_q  <= 1'b0;
            x_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            gray_q  <= gray_d;
            x_q     <= x_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_ortho_symbol_mapper.sv
// tb_ortho_symbol_mapper
//   Self-checking bench: directed scenarios on the default configuration plus
//   randomized runs on three configurations against a queue-based model.
module tb_ortho_symbol_mapper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default 3 dims x 2 bits, 4 symbols/word
    logic [23:0] in_data_a;
    logic        in_valid_a, in_ready_a, gray_en_a, out_valid_a, out_ready_a, out_last_a;
    logic [5:0]  x_a;
    // Instance B: 3 dims x 2 bits, 1 symbol/word
    logic [5:0]  in_data_b;
    logic        in_valid_b, in_ready_b, gray_en_b, out_valid_b, out_ready_b, out_last_b;
    logic [5:0]  x_b;
    // Instance C: 1 dim x 1 bit, 4 symbols/word
    logic [3:0]  in_data_c;
    logic        in_valid_c, in_ready_c, gray_en_c, out_valid_c, out_ready_c, out_last_c;
    logic [0:0]  x_c;

    ortho_symbol_mapper u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .gray_en(gray_en_a), .x(x_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_last(out_last_a)
    );

    ortho_symbol_mapper #(.NUM_DIMS(3), .DIM_WIDTH(2), .SYMS_PER_WORD(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .gray_en(gray_en_b), .x(x_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_last(out_last_b)
    );

    ortho_symbol_mapper #(.NUM_DIMS(1), .DIM_WIDTH(1), .SYMS_PER_WORD(4)) u_dut_c (
        .clk(clk), .rst(rst), .in_data(in_data_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .gray_en(gray_en_c), .x(x_c), .out_valid(out_valid_c),
        .out_ready(out_ready_c), .out_last(out_last_c)
    );

    // Reference: symbol s of word w, each level extracted arithmetically and
    // Gray-coded as b ^ floor(b/2) when g is set.
    function automatic logic [63:0] model_sym(input logic [63:0] w, input int s,
                                              input bit g, input int nd, input int dw);
        logic [63:0] r = 0;
        logic [63:0] b;
        for (int d = 0; d < nd; d++) begin
            b = (w >> (s * nd * dw + d * dw)) % (64'd1 << dw);
            if (g) b = b ^ (b / 2);
            r = r + (b << (d * dw));
        end
        return r;
    endfunction

    // One word through instance A; optional stall of stall_n cycles on symbol stall_at.
    task automatic drive_word(input logic [23:0] w, input logic g, input logic [5:0] exp [4],
                              input int stall_at, input int stall_n, input string tag);
        int hold;
        @(negedge clk);
        in_valid_a = 1'b1; in_data_a = w; gray_en_a = g; out_ready_a = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL %s accept_ready: got %b want 1", tag, in_ready_a); end
        for (int s = 0; s < 4; s++) begin
            hold = (s == stall_at) ? stall_n : 0;
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                in_valid_a = 1'b0; in_data_a = 24'($urandom); gray_en_a = ~g;
                out_ready_a = (h == hold);
                checks++; if (x_a !== exp[s]) begin errors++; $display("FAIL %s x sym%0d cyc%0d: got %h want %h", tag, s, h, x_a, exp[s]); end
                checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL %s out_valid sym%0d: got %b want 1", tag, s, out_valid_a); end
                checks++; if (out_last_a !== (s == 3)) begin errors++; $display("FAIL %s out_last sym%0d: got %b want %b", tag, s, out_last_a, s == 3); end
                #1;
                checks++; if (in_ready_a !== (s == 3 && h == hold)) begin errors++; $display("FAIL %s in_ready sym%0d cyc%0d: got %b want %b", tag, s, h, in_ready_a, s == 3 && h == hold); end
            end
        end
        @(negedge clk);
        out_ready_a = 1'b1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL %s idle_after: out_valid got %b want 0", tag, out_valid_a); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid_a = 0; in_data_a = '0; gray_en_a = 0; out_ready_a = 0;
        in_valid_b = 0; in_data_b = '0; gray_en_b = 0; out_ready_b = 0;
        in_valid_c = 0; in_data_c = '0; gray_en_c = 0; out_ready_c = 0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid_a); end
        checks++; if (x_a !== 6'h00) begin errors++; $display("FAIL reset x: got %h want 00", x_a); end
        checks++; if (out_last_a !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b want 0", out_last_a); end
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready_a); end
        checks++; if (out_valid_b !== 1'b0 || out_valid_c !== 1'b0) begin errors++; $display("FAIL reset sweep out_valid: got %b%b want 00", out_valid_b, out_valid_c); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [5:0] e [4];
        e = '{6'h1B, 6'h00, 6'h3F, 6'h24};
        drive_word(24'h93F01B, 1'b0, e, -1, 0, "basic");
    endtask

    task automatic test_gray();
        logic [5:0] e [4];
        e = '{6'h1E, 6'h00, 6'h2A, 6'h34};
        drive_word(24'h93F01B, 1'b1, e, -1, 0, "gray");
    endtask

    task automatic test_backpressure();
        logic [5:0] e [4];
        e = '{6'h1B, 6'h00, 6'h3F, 6'h24};
        drive_word(24'h93F01B, 1'b0, e, 1, 3, "backpressure");
    endtask

    task automatic test_back_to_back();
        logic [23:0] wa, wb;
        bit ga, gb;
        logic [5:0] e;
        wa = 24'($urandom); wb = 24'($urandom);
        ga = 1'($urandom); gb = 1'($urandom);
        @(negedge clk);
        in_valid_a = 1'b1; in_data_a = wa; gray_en_a = ga; out_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            e = (i < 4) ? 6'(model_sym(64'(wa), i, ga, 3, 2)) : 6'(model_sym(64'(wb), i - 4, gb, 3, 2));
            checks++; if (x_a !== e) begin errors++; $display("FAIL b2b x cyc%0d: got %h want %h", i, x_a, e); end
            checks++; if (out_valid_a !== 1'b1) begin errors++; $display("FAIL b2b out_valid cyc%0d: got %b want 1", i, out_valid_a); end
            checks++; if (out_last_a !== (i % 4 == 3)) begin errors++; $display("FAIL b2b out_last cyc%0d: got %b want %b", i, out_last_a, i % 4 == 3); end
            in_valid_a = (i <= 3); in_data_a = wb; gray_en_a = gb;
            #1;
            checks++; if (in_ready_a !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b in_ready cyc%0d: got %b want %b", i, in_ready_a, i == 3 || i == 7); end
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL b2b idle_after: out_valid got %b want 0", out_valid_a); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] w;
        logic [5:0] e1;
        w  = 24'h5A5FC1;
        e1 = 6'(model_sym(64'(w), 1, 1'b0, 3, 2));
        @(negedge clk);
        in_valid_a = 1'b1; in_data_a = w; gray_en_a = 1'b0; out_ready_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        @(negedge clk);
        checks++; if (x_a !== e1) begin errors++; $display("FAIL rst_mid pre x: got %h want %h", x_a, e1); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b want 0", out_valid_a); end
        checks++; if (x_a !== 6'h00) begin errors++; $display("FAIL rst_mid x: got %h want 00", x_a); end
        checks++; if (out_last_a !== 1'b0) begin errors++; $display("FAIL rst_mid out_last: got %b want 0", out_last_a); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL rst_mid stale cyc%0d: out_valid got %b want 0", i, out_valid_a); end
            #1;
            checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready cyc%0d: got %b want 1", i, in_ready_a); end
        end
    endtask

    task automatic test_random_default(input int n);
        logic [63:0] q[$];
        logic [23:0] w;
        bit g, mr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++; if (out_valid_a !== (q.size() > 0)) begin errors++; $display("FAIL rand_a out_valid cyc%0d: got %b want %b", i, out_valid_a, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (x_a !== q[0][5:0]) begin errors++; $display("FAIL rand_a x cyc%0d: got %h want %h", i, x_a, q[0][5:0]); end
                checks++; if (out_last_a !== (q.size() == 1)) begin errors++; $display("FAIL rand_a out_last cyc%0d: got %b want %b", i, out_last_a, q.size() == 1); end
            end
            w = 24'($urandom); g = 1'($urandom);
            in_valid_a = ($urandom_range(0, 3) != 0); in_data_a = w; gray_en_a = g;
            out_ready_a = ($urandom_range(0, 3) != 0);
            mr = (q.size() == 0) || (out_ready_a && q.size() == 1);
            #1;
            checks++; if (in_ready_a !== mr) begin errors++; $display("FAIL rand_a in_ready cyc%0d: got %b want %b", i, in_ready_a, mr); end
            if (q.size() > 0 && out_ready_a) void'(q.pop_front());
            if (in_valid_a && mr) for (int s = 0; s < 4; s++) q.push_back(model_sym(64'(w), s, g, 3, 2));
        end
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_sweep_syms1(input int n);
        logic [63:0] q[$];
        logic [5:0] w;
        bit g, mr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++; if (out_valid_b !== (q.size() > 0)) begin errors++; $display("FAIL syms1 out_valid cyc%0d: got %b want %b", i, out_valid_b, q.size() > 0); end
            checks++; if (out_last_b !== (q.size() > 0)) begin errors++; $display("FAIL syms1 out_last cyc%0d: got %b want %b", i, out_last_b, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (x_b !== q[0][5:0]) begin errors++; $display("FAIL syms1 x cyc%0d: got %h want %h", i, x_b, q[0][5:0]); end
            end
            w = 6'($urandom); g = 1'($urandom);
            in_valid_b = ($urandom_range(0, 3) != 0); in_data_b = w; gray_en_b = g;
            out_ready_b = ($urandom_range(0, 3) != 0);
            mr = (q.size() == 0) || (out_ready_b && q.size() == 1);
            #1;
            checks++; if (in_ready_b !== mr) begin errors++; $display("FAIL syms1 in_ready cyc%0d: got %b want %b", i, in_ready_b, mr); end
            if (q.size() > 0 && out_ready_b) void'(q.pop_front());
            if (in_valid_b && mr) q.push_back(model_sym(64'(w), 0, g, 3, 2));
        end
        in_valid_b = 1'b0; out_ready_b = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sweep_dim1(input int n);
        logic [63:0] q[$];
        logic [3:0] w;
        bit g, mr;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++; if (out_valid_c !== (q.size() > 0)) begin errors++; $display("FAIL dim1 out_valid cyc%0d: got %b want %b", i, out_valid_c, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (x_c !== q[0][0:0]) begin errors++; $display("FAIL dim1 x cyc%0d: got %h want %h", i, x_c, q[0][0:0]); end
                checks++; if (out_last_c !== (q.size() == 1)) begin errors++; $display("FAIL dim1 out_last cyc%0d: got %b want %b", i, out_last_c, q.size() == 1); end
            end
            w = 4'($urandom); g = 1'($urandom);
            in_valid_c = ($urandom_range(0, 3) != 0); in_data_c = w; gray_en_c = g;
            out_ready_c = ($urandom_range(0, 3) != 0);
            mr = (q.size() == 0) || (out_ready_c && q.size() == 1);
            #1;
            checks++; if (in_ready_c !== mr) begin errors++; $display("FAIL dim1 in_ready cyc%0d: got %b want %b", i, in_ready_c, mr); end
            if (q.size() > 0 && out_ready_c) void'(q.pop_front());
            if (in_valid_c && mr) for (int s = 0; s < 4; s++) q.push_back(model_sym(64'(w), s, g, 1, 1));
        end
        in_valid_c = 1'b0; out_ready_c = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gray();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random_default(300);
        test_sweep_syms1(200);
        test_sweep_dim1(200);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
